// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: each IN_WIDTH-bit word leaves as RATIO OUT_WIDTH-bit beats.
// Beats go least-significant slice first; defining AXIS_DOWNSIZER_MSB_FIRST_EN sends the most-significant slice first.
module axis_width_downsizer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((RATIO < 2) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_bad_ratio
        $error("axis_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                            state_q, state_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0]   word_q, word_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [IDX_W-1:0]                  sel;
    logic                              isLast;

    assign isLast = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    // On the last beat a waiting word is loaded on the same edge, so there is no bubble.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!isLast) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (in_valid) begin
                        word_d = in_data;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
    assign sel = LAST_IDX - idx_q;
`else
    assign sel = idx_q;
`endif

    // Every output is gated by resetn so the reset values show even before the first reset edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (resetn) begin
            out_data = word_q[sel];
            case (state_q)
                IDLE: in_ready = 1'b1;
                SEND: begin
                    out_valid = 1'b1;
                    out_last  = isLast;
                    in_ready  = isLast & out_ready;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed self-checking bench for axis_width_downsizer (IN_WIDTH=16, OUT_WIDTH=4).
// Expected beat order follows AXIS_DOWNSIZER_MSB_FIRST_EN, the same as the design.
module tb_axis_width_downsizer;

    logic        clk;
    logic        resetn;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int testsRun;
    int testsFailed;

    axis_width_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat k of a 16-bit word, as a narrow sink must see it.
    function automatic logic [3:0] nib(input logic [15:0] w, input int k);
`ifdef AXIS_DOWNSIZER_MSB_FIRST_EN
        return w[(3 - k) * 4 +: 4];
`else
        return w[k * 4 +: 4];
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bpIdx[6];
        logic bpReady[6];
        logic [15:0] w;
        testsRun    = 0;
        testsFailed = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;

        // Reset held for three cycles with no input.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_out_valid", {15'b0, out_valid}, 16'h0);
            checkOutput("rst_out_data", {12'b0, out_data}, 16'h0);
            checkOutput("rst_in_ready", {15'b0, in_ready}, 16'h0);
            checkOutput("rst_out_last", {15'b0, out_last}, 16'h0);
        end
        applyStimulus();
        resetn = 1'b1;
        applyStimulus();
        @(negedge clk);
        checkOutput("idle_in_ready", {15'b0, in_ready}, 16'h1);
        checkOutput("idle_out_valid", {15'b0, out_valid}, 16'h0);

        // Single word 0xABCD with the sink always ready.
        applyStimulus();
        in_valid  = 1'b1;
        in_data   = 16'hABCD;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("single_accept_ready", {15'b0, in_ready}, 16'h1);
        checkOutput("single_pre_valid", {15'b0, out_valid}, 16'h0);
        applyStimulus();
        in_valid = 1'b0;
        in_data  = 16'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("single_valid", {15'b0, out_valid}, 16'h1);
            checkOutput("single_data", {12'b0, out_data}, {12'b0, nib(16'hABCD, k)});
            checkOutput("single_last", {15'b0, out_last}, {15'b0, k == 3});
            checkOutput("single_in_ready", {15'b0, in_ready}, {15'b0, k == 3});
            applyStimulus();
        end
        @(negedge clk);
        checkOutput("single_done_valid", {15'b0, out_valid}, 16'h0);

        // Two words offered back to back: eight beats, no gap.
        applyStimulus();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        applyStimulus();
        in_data = 16'h5678;
        for (int k = 0; k < 8; k++) begin
            w = (k < 4) ? 16'h1234 : 16'h5678;
            @(negedge clk);
            checkOutput("b2b_valid", {15'b0, out_valid}, 16'h1);
            checkOutput("b2b_data", {12'b0, out_data}, {12'b0, nib(w, k % 4)});
            checkOutput("b2b_last", {15'b0, out_last}, {15'b0, (k % 4) == 3});
            checkOutput("b2b_in_ready", {15'b0, in_ready}, {15'b0, (k % 4) == 3});
            applyStimulus();
            if (k == 3) begin
                in_valid = 1'b0;
                in_data  = 16'h0;
            end
        end
        @(negedge clk);
        checkOutput("b2b_done_valid", {15'b0, out_valid}, 16'h0);

        // Backpressure on word 0x00F0: ready pattern 1,0,0,1,1,1.
        bpReady = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bpIdx   = '{0, 1, 1, 1, 2, 3};
        applyStimulus();
        in_valid = 1'b1;
        in_data  = 16'h00F0;
        applyStimulus();
        in_valid = 1'b0;
        in_data  = 16'h0;
        for (int c = 0; c < 6; c++) begin
            out_ready = bpReady[c];
            @(negedge clk);
            checkOutput("bp_valid", {15'b0, out_valid}, 16'h1);
            checkOutput("bp_data", {12'b0, out_data}, {12'b0, nib(16'h00F0, bpIdx[c])});
            checkOutput("bp_last", {15'b0, out_last}, {15'b0, bpIdx[c] == 3});
            checkOutput("bp_in_ready", {15'b0, in_ready}, {15'b0, c == 5});
            applyStimulus();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_done_valid", {15'b0, out_valid}, 16'h0);

        // Reset after two beats of 0xABCD have been delivered.
        applyStimulus();
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        applyStimulus();
        in_valid = 1'b0;
        in_data  = 16'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("midrst_data", {12'b0, out_data}, {12'b0, nib(16'hABCD, k)});
            applyStimulus();
        end
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", {15'b0, out_valid}, 16'h0);
        checkOutput("midrst_out_data", {12'b0, out_data}, 16'h0);
        checkOutput("midrst_in_ready", {15'b0, in_ready}, 16'h0);
        applyStimulus();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("postrst_valid", {15'b0, out_valid}, 16'h0);
            checkOutput("postrst_in_ready", {15'b0, in_ready}, 16'h1);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axis_width_downsizer.md
# axis_width_downsizer

Stream width converter that sits directly downstream of the stream FIFO. It accepts one IN_WIDTH-bit word per handshake and emits it as RATIO consecutive OUT_WIDTH-bit beats, for narrow sinks such as serialisers and byte-wide links. A registered holding stage provides full throughput: with the sink always ready, a new word is accepted on the same cycle the previous word's last beat leaves.

## Interface
Parameters:
- IN_WIDTH, 16, input word width in bits.
- OUT_WIDTH, 4, output beat width in bits.
- Legality: IN_WIDTH must be an integer multiple of OUT_WIDTH.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH. RATIO ≥ 2 is required; any violation is an elaboration-time $error.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- in_data  in  IN_WIDTH  upstream word.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  downsizer can accept a word.
- out_data  out  OUT_WIDTH  current narrow beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  current beat is the final beat of its word.

## Operation
- Storage: hold register `word` (IN_WIDTH bits) and beat counter `idx` (width $clog2(RATIO)).
- State machine:
  - IDLE (out_valid=0): in_valid & in_ready loads `word`, sets idx=0 and goes to SEND.
  - SEND (out_valid=1): out_data = slice idx of `word`.
  - SEND, out_ready=1, idx<RATIO-1: idx increments.
  - SEND, out_ready=1, idx=RATIO-1 (last beat), in_valid=1: loads the next word, sets idx=0 and stays in SEND.
  - SEND, out_ready=1, idx=RATIO-1 (last beat), in_valid=0: returns to IDLE.
  - SEND, out_ready=0: holds all state.
- in_ready = resetn & (IDLE | (SEND & idx==RATIO-1 & out_ready)).
  - This is the only combinational path from out_ready to in_ready.
  - in_ready does not depend on in_valid.
- out_last = SEND & idx==RATIO-1.
- out_data is driven from a register/mux of registered state only; there is no combinational path from in_data.
- Slice order (default): beat k = word[k*OUT_WIDTH +: OUT_WIDTH], least-significant first.
- No packet framing: each word is independent, and out_last marks word boundaries only.

## Timing
- Reset values, forced during every cycle with resetn=0, regardless of other inputs:
  - out_valid=0, out_last=0, out_data=0.
  - idx=0, word=0, state=IDLE.
  - in_ready=0.
- First clock edge with resetn=1: in_ready=1.
- Latency: word accepted at edge N → beat 0 valid after edge N (cycle N+1). Beat k appears no earlier than cycle N+1+k.
- Throughput with out_ready held high:
  - one beat per cycle;
  - one word per RATIO cycles;
  - no bubble between words.
- AXI-Stream rules:
  - Once out_valid=1, out_data, out_last and out_valid hold stable until out_ready=1.
  - in_data is sampled only on the edge where in_valid & in_ready.
- Simultaneous last-beat handshake and input handshake: both complete on the same edge; the new word's beat 0 is presented the next cycle.
- Reset mid-word: the remaining beats are discarded and outputs return to reset values on that edge. No partial word is emitted after reset.
- Counter wrap: idx never exceeds RATIO-1, including for non-power-of-two RATIO (e.g. RATIO=3 counts 0,1,2,0).

## Configuration
- Macro AXIS_DOWNSIZER_MSB_FIRST_EN.
  - Defined: beat k = word[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH], most-significant first.
  - Undefined (default): least-significant slice first.
- Handshake, latency and out_last behaviour are identical in both builds.

## Test plan
- Reset then idle:
  - Stimulus: resetn=0 for 3 cycles, then 1, with no input.
  - Required: out_valid=0, out_data=0 and in_ready=0 during reset; in_ready=1 after the first edge with resetn=1.
- Single word, LSB build (IN=16, OUT=4):
  - Stimulus: one beat 0xABCD, out_ready=1.
  - Required: out_data D, C, B, A on 4 consecutive cycles starting 1 cycle after acceptance; out_last=1 only on A.
- Single word, MSB build (AXIS_DOWNSIZER_MSB_FIRST_EN defined):
  - Stimulus: same as the LSB case (0xABCD, out_ready=1).
  - Required: out_data A, B, C, D; out_last only on D.
- Back-to-back:
  - Stimulus: 0x1234 and 0x5678 offered continuously, out_ready=1.
  - Required: 8 beats (LSB build: 4,3,2,1,8,7,6,5) in 8 consecutive cycles with no gap; in_ready pulses on the last-beat cycle.
- Backpressure:
  - Stimulus: word 0x00F0; out_ready toggles 1,0,0,1,1,1.
  - Required: beat 0x0 is accepted. Beat 0xF is then held stable through both stall cycles, followed by 0x0 and 0x0. in_ready=0 throughout until the last handshake.
- Reset mid-word:
  - Stimulus: word 0xABCD accepted; resetn=0 after 2 beats delivered.
  - Required: the next cycle shows out_valid=0, and no further beats of 0xABCD appear after reset release.
